advance: RTL
============

# advance

Per-packet sample advance for RFNoC sample streams. Drops the first `len` samples of every packet and appends `len` zero samples before the packet ends, so output packet length equals input packet length. Sits on the same AXI-stream sample path as the delay-line block and undoes that block's zero-fill delay. Needs no sample memory: one counter, one state register and a single registered output stage.

## Interface

**Parameters**
- `MAX_LEN_LOG2`, default 10. `len` is `MAX_LEN_LOG2+1` bits wide.
- `WIDTH`, default 16. Sample width in bits.

**Ports**
- `clk` input, 1 bit. Clock.
- `reset` input, 1 bit. Synchronous, active-high.
- `clear` input, 1 bit. Synchronous, active-high; same effect as `reset`.
- `len` input, `MAX_LEN_LOG2+1` bits. Advance in samples; sampled only at packet boundaries.
- `i_tdata` input, `WIDTH` bits. Input sample.
- `i_tlast` input, 1 bit. Last sample of input packet.
- `i_tvalid` input, 1 bit. Input valid.
- `i_tready` output, 1 bit. Input ready.
- `o_tdata` output, `WIDTH` bits. Output sample (registered).
- `o_tlast` output, 1 bit. Last sample of output packet (registered).
- `o_tvalid` output, 1 bit. Output valid (registered).
- `o_tready` input, 1 bit. Output ready.

## Operation

- **Internal state:** `len_r` (latched len), `cnt` (`MAX_LEN_LOG2+1` bits), `state` ∈ {SKIP, PASS, PAD}.
- **Output register:** `ofree = ~o_tvalid | o_tready`. The register loads only when `ofree`.
- **Reload action:** `len_r <= len`, `cnt <= 0`, `state <= (len==0) ? PASS : SKIP`. Happens on reset/clear and at every packet end.
- **SKIP:**
  - `i_tready = 1`; accepted beats are discarded, and the output register is unaffected and drains normally.
  - Each accepted beat: `cnt <= cnt+1`.
  - On a beat with `i_tlast` (short packet, length ≤ `len_r`): `cnt <= cnt+1`, go to PAD. The pad count equals the number of samples consumed.
  - Else if `cnt+1 == len_r`: go to PASS.
- **PASS:**
  - `i_tready = ofree`.
  - Accepted beat loads `o_tdata <= i_tdata`, `o_tvalid <= 1`.
  - If `i_tlast` and `len_r == 0`: `o_tlast <= 1`, then reload.
  - If `i_tlast` and `len_r != 0`: `o_tlast <= 0`, `cnt <= len_r`, go to PAD.
  - Otherwise `o_tlast <= 0`.
- **PAD:**
  - `i_tready = 0`.
  - While `ofree`: load `o_tdata <= 0`, `o_tvalid <= 1`, `cnt <= cnt-1`, `o_tlast <= (cnt == 1)`.
  - When `cnt == 1` is loaded, reload.
- **No input in flight:** if `ofree` and there is no input or pad beat, `o_tvalid <= 0`.
- **Counts:**
  - Output samples per packet always equal input samples per packet.
  - Exactly one `o_tlast` per input packet.
  - Zero samples are all-zero `WIDTH` bits.
- **Arithmetic:** `cnt` never wraps. SKIP stops at `len_r` and PAD stops at 1. Max `len` is `2^(MAX_LEN_LOG2+1)-1`.
- **`len` changes:** changes mid-packet are ignored until the next reload.

## Timing

- **Reset/clear values:** `o_tvalid = 0`, `o_tlast = 0`, `o_tdata = 0`, `i_tready` per the reloaded state (1 in SKIP, 1 in PASS since the output register is empty). Any held output beat is discarded.
- **PASS latency:** 1 cycle, accepted input to `o_tvalid`.
- **PASS throughput:** 1 sample/cycle with `o_tready` held high.
- **PASS → PAD:** the first zero loads on the cycle after the `tlast` beat is accepted, provided `ofree`. PAD then emits 1 zero/cycle under full throughput.
- **SKIP throughput:** consumes 1 sample/cycle regardless of `o_tready`.
- **Packet start after PAD:** the first beat of the next packet is accepted the cycle after the final zero is loaded.
- **AXI rules:**
  - `o_tdata`, `o_tlast` and `o_tvalid` are stable while `o_tvalid & ~o_tready`.
  - `o_tvalid` never drops without a handshake, except on reset/clear.
- **Simultaneous events:**
  - Reset/clear wins over any handshake in the same cycle.
  - In PAD, `i_tvalid` is ignored.

## Test plan

- **Basic advance:** `len=3`, packet 1..8 with `tlast` on 8, `o_tready=1` → output 4,5,6,7,8,0,0,0 with `tlast` only on the last 0; 8 beats total.
- **Passthrough:** `len=0`, packets of 1 and 5 samples → identical data and `tlast`, 1-cycle latency, no gaps.
- **Short packet:** `len=5`, 3-sample packet A,B,C → three zeros, `tlast` on the third. Then `len=5`, 5-sample packet → five zeros.
- **Backpressure:** `len=2`, 100 packets of random length 1–40, random `o_tready` and `i_tvalid` → output matches a reference model beat-for-beat; held output is stable while stalled.
- **`len` change and clear:** change `len` 3→1 mid-packet → current packet still uses 3, the next uses 1. Assert `clear` in the middle of PAD → `o_tvalid=0` next cycle and the next packet starts fresh in SKIP.
- **Reset values:** check all outputs immediately after `reset`; `len=2047` with a 2048-sample packet → 1 data sample + 2047 zeros.

Source files
------------

// File: rtl/advance.sv
// Per-packet sample advance: drops the first len samples of each packet and
// appends len zero samples so that output packet length equals input length.
module advance #(
  parameter int MAX_LEN_LOG2 = 10,
  parameter int WIDTH        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [MAX_LEN_LOG2:0]   len,
  input  logic [WIDTH-1:0]        i_tdata,
  input  logic                    i_tlast,
  input  logic                    i_tvalid,
  output logic                    i_tready,
  output logic [WIDTH-1:0]        o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready
);

  localparam int LW = MAX_LEN_LOG2 + 1;
  localparam logic [LW-1:0] CNT_ONE = {{(LW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_SKIP = 2'd0,
    ST_PASS = 2'd1,
    ST_PAD  = 2'd2
  } state_t;

  state_t          state_r;
  logic [LW-1:0]   len_r;
  logic [LW-1:0]   cnt_r;
  logic            ofree_s;
  logic            accept_s;
  logic [LW-1:0]   cnt_inc_s;
  logic [LW-1:0]   cnt_dec_s;

  // Output-register availability, input ready per state, and counter steps.
  always_comb begin
    ofree_s   = ~o_tvalid | o_tready;
    cnt_inc_s = cnt_r + CNT_ONE;
    cnt_dec_s = cnt_r - CNT_ONE;
    case (state_r)
      ST_SKIP: i_tready = 1'b1;
      ST_PASS: i_tready = ofree_s;
      ST_PAD:  i_tready = 1'b0;
      default: i_tready = 1'b0;
    endcase
    if (i_tvalid && i_tready) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Packet state machine with the single registered output stage.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      len_r    <= len;
      cnt_r    <= '0;
      state_r  <= (len == '0) ? ST_PASS : ST_SKIP;
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      o_tdata  <= '0;
    end else begin
      case (state_r)
        ST_SKIP: begin
          // Discarded beats never touch the output; it just drains.
          if (ofree_s) begin
            o_tvalid <= 1'b0;
          end
          if (accept_s) begin
            cnt_r <= cnt_inc_s;
            if (i_tlast) begin
              state_r <= ST_PAD;
            end else if (cnt_inc_s == len_r) begin
              state_r <= ST_PASS;
            end
          end
        end
        ST_PASS: begin
          if (accept_s) begin
            o_tdata  <= i_tdata;
            o_tvalid <= 1'b1;
            if (i_tlast && (len_r == '0)) begin
              o_tlast <= 1'b1;
              len_r   <= len;
              cnt_r   <= '0;
              state_r <= (len == '0) ? ST_PASS : ST_SKIP;
            end else if (i_tlast) begin
              o_tlast <= 1'b0;
              cnt_r   <= len_r;
              state_r <= ST_PAD;
            end else begin
              o_tlast <= 1'b0;
            end
          end else if (ofree_s) begin
            o_tvalid <= 1'b0;
          end
        end
        ST_PAD: begin
          if (ofree_s) begin
            o_tdata  <= '0;
            o_tvalid <= 1'b1;
            o_tlast  <= (cnt_r == CNT_ONE);
            cnt_r    <= cnt_dec_s;
            // Final zero loaded: reload for the next packet.
            if (cnt_r == CNT_ONE) begin
              len_r   <= len;
              cnt_r   <= '0;
              state_r <= (len == '0) ? ST_PASS : ST_SKIP;
            end
          end
        end
        default: begin
          len_r    <= len;
          cnt_r    <= '0;
          state_r  <= (len == '0) ? ST_PASS : ST_SKIP;
          o_tvalid <= 1'b0;
          o_tlast  <= 1'b0;
          o_tdata  <= '0;
        end
      endcase
    end
  end

endmodule
